// File: rtl/pkt_st_pkg.sv
// -----------------------------------------------------------------------------
// pkt_st_pkg
// Shared definitions for the packet-level Avalon-ST mux/demux pair.
//   DATA_W / EMPTY_W : beat data width and empty-byte count width
//   st_beat_t        : one buffered beat {data, sop, eop, empty}
//   demux_state_t    : demultiplexer packet-tracking states
// -----------------------------------------------------------------------------
package pkt_st_pkg;

    localparam int unsigned DATA_W  = 512;
    localparam int unsigned EMPTY_W = 6;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } st_beat_t;

    typedef enum logic [1:0] {
        DMX_IDLE,
        DMX_FWD,
        DMX_DROP
    } demux_state_t;

endpackage

// File: rtl/st_demux_pkt_if.sv
// -----------------------------------------------------------------------------
// st_demux_pkt_if
// Ingress stream plus NUM_OUT egress streams of the packet demultiplexer.
//   in_*  : ingress beat, SOP/EOP/empty, channel sideband, valid/ready
//   out_* : egress streams, slice i of each vector belongs to egress i
// Modports:
//   slave  : the demultiplexer (consumes ingress, drives egress)
//   master : the environment (drives ingress, consumes egress)
// -----------------------------------------------------------------------------
interface st_demux_pkt_if
    import pkt_st_pkg::*;
#(
    parameter int unsigned NUM_OUT = 3,
    parameter int unsigned CH_W    = 2
) ();

    logic [DATA_W-1:0]          in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_startofpacket;
    logic                       in_endofpacket;
    logic [EMPTY_W-1:0]         in_empty;
    logic [CH_W-1:0]            in_channel;

    logic [NUM_OUT*DATA_W-1:0]  out_data;
    logic [NUM_OUT-1:0]         out_valid;
    logic [NUM_OUT-1:0]         out_ready;
    logic [NUM_OUT-1:0]         out_startofpacket;
    logic [NUM_OUT-1:0]         out_endofpacket;
    logic [NUM_OUT*EMPTY_W-1:0] out_empty;

    modport slave (
        input  in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, in_channel,
        output in_ready,
        output out_data, out_valid, out_startofpacket, out_endofpacket, out_empty,
        input  out_ready
    );

    modport master (
        output in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, in_channel,
        input  in_ready,
        input  out_data, out_valid, out_startofpacket, out_endofpacket, out_empty,
        output out_ready
    );

endinterface

// File: rtl/st_demux_pkt_skid2.sv
// -----------------------------------------------------------------------------
// st_skid2
// Two-entry valid/ready skid buffer for one egress stream. Outputs come
// straight from the head register; o_full is a register bit so the
// upstream ready never depends on the downstream ready.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   i_push     : write i_beat this cycle (caller guarantees ~o_full)
//   i_beat     : beat to store
//   o_full     : both entries occupied
//   o_valid    : head entry valid
//   i_ready    : downstream ready
//   o_beat     : head entry
// -----------------------------------------------------------------------------
module st_skid2
    import pkt_st_pkg::*;
(
    input  logic     Clk,
    input  logic     Rst_n,
    input  logic     i_push,
    input  st_beat_t i_beat,
    output logic     o_full,
    output logic     o_valid,
    input  logic     i_ready,
    output st_beat_t o_beat
);

    st_beat_t r_head;
    st_beat_t r_tail;
    logic     r_head_vld;
    logic     r_tail_vld;
    logic     w_pop;

    assign w_pop = r_head_vld & i_ready;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_head_vld <= 1'b0;
            r_tail_vld <= 1'b0;
        end else if (w_pop) begin
            // Tail (if any) advances to head; a simultaneous push refills
            // whichever slot has just been vacated.
            if (r_tail_vld) begin
                r_head <= r_tail;
                if (i_push) r_tail <= i_beat;
                else        r_tail_vld <= 1'b0;
            end else begin
                if (i_push) r_head <= i_beat;
                else        r_head_vld <= 1'b0;
            end
        end else if (i_push) begin
            if (!r_head_vld) begin
                r_head     <= i_beat;
                r_head_vld <= 1'b1;
            end else if (!r_tail_vld) begin
                r_tail     <= i_beat;
                r_tail_vld <= 1'b1;
            end
        end
    end

    assign o_full  = r_tail_vld;
    assign o_valid = r_head_vld;
    assign o_beat  = r_head;

endmodule

// File: rtl/st_demux_pkt.sv
// -----------------------------------------------------------------------------
// st_demux_pkt
// Packet-atomic Avalon-ST demultiplexer. The egress channel is latched on
// the SOP beat and held until EOP; packets for channels >= NUM_OUT are
// discarded. Each egress has a 2-entry skid buffer.
//   Clk, Rst_n   : clock, asynchronous active-low reset
//   st           : ingress/egress stream bundle (slave side)
//   drop_pkt_cnt : saturating count of packets dropped for invalid channel
//   err_beat_cnt : saturating count of protocol-error beats
// -----------------------------------------------------------------------------
module st_demux_pkt
    import pkt_st_pkg::*;
#(
    parameter int unsigned NUM_OUT = 3,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned CNT_W   = 32
)
(
    input  logic             Clk,
    input  logic             Rst_n,
    st_demux_pkt_if.slave    st,
    output logic [CNT_W-1:0] drop_pkt_cnt,
    output logic [CNT_W-1:0] err_beat_cnt
);

    demux_state_t       r_state, w_state_nxt;
    logic [CH_W-1:0]    r_cur_ch, w_cur_ch_nxt;
    logic [CNT_W-1:0]   r_drop_cnt, r_err_cnt;
    logic [NUM_OUT-1:0] w_full, w_push, w_out_valid;
    st_beat_t           w_beat;
    st_beat_t           w_out_beat [NUM_OUT];
    logic               w_ch_ok, w_in_full, w_cur_full;
    logic               w_in_ready, w_acc, w_push_en, w_drop_inc, w_err_inc;
    logic [CH_W-1:0]    w_dst;

    assign w_ch_ok = (32'(st.in_channel) < NUM_OUT);

    always_comb begin
        w_in_full  = 1'b0;
        w_cur_full = 1'b0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (32'(st.in_channel) == i) w_in_full  = w_full[i];
            if (32'(r_cur_ch) == i)      w_cur_full = w_full[i];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_ch_nxt = r_cur_ch;
        w_in_ready   = 1'b0;
        w_acc        = 1'b0;
        w_push_en    = 1'b0;
        w_dst        = r_cur_ch;
        w_drop_inc   = 1'b0;
        w_err_inc    = 1'b0;
        w_beat.data  = st.in_data;
        w_beat.sop   = st.in_startofpacket;
        w_beat.eop   = st.in_endofpacket;
        w_beat.empty = st.in_empty;
        unique case (r_state)
            DMX_IDLE: begin
                w_in_ready = w_ch_ok ? ~w_in_full : 1'b1;
                w_acc      = st.in_valid & w_in_ready & Rst_n;
                if (w_acc) begin
                    if (!st.in_startofpacket) begin
                        w_err_inc = 1'b1;
                    end else if (w_ch_ok) begin
                        w_push_en    = 1'b1;
                        w_dst        = st.in_channel;
                        w_cur_ch_nxt = st.in_channel;
                        if (!st.in_endofpacket) w_state_nxt = DMX_FWD;
                    end else begin
                        w_drop_inc = 1'b1;
                        if (!st.in_endofpacket) w_state_nxt = DMX_DROP;
                    end
                end
            end
            DMX_FWD: begin
                w_in_ready = ~w_cur_full;
                w_acc      = st.in_valid & w_in_ready & Rst_n;
                if (w_acc) begin
                    w_push_en = 1'b1;
                    // A stray SOP inside a packet is counted but the beat
                    // still belongs to the current packet.
                    if (st.in_startofpacket) begin
                        w_err_inc  = 1'b1;
                        w_beat.sop = 1'b0;
                    end
                    if (st.in_endofpacket) w_state_nxt = DMX_IDLE;
                end
            end
            DMX_DROP: begin
                w_in_ready = 1'b1;
                w_acc      = st.in_valid & Rst_n;
                if (w_acc) begin
                    if (st.in_startofpacket) w_err_inc = 1'b1;
                    if (st.in_endofpacket)   w_state_nxt = DMX_IDLE;
                end
            end
            default: w_state_nxt = DMX_IDLE;
        endcase
        w_in_ready = w_in_ready & Rst_n;
    end

    always_comb begin
        w_push = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            w_push[i] = w_push_en && (32'(w_dst) == i);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= DMX_IDLE;
            r_cur_ch <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur_ch <= w_cur_ch_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_err_inc  && (r_err_cnt  != '1)) r_err_cnt  <= r_err_cnt  + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_egress
        st_skid2 u_skid (
            .Clk     (Clk),
            .Rst_n   (Rst_n),
            .i_push  (w_push[g]),
            .i_beat  (w_beat),
            .o_full  (w_full[g]),
            .o_valid (w_out_valid[g]),
            .i_ready (st.out_ready[g]),
            .o_beat  (w_out_beat[g])
        );
    end

    always_comb begin
        st.out_data          = '0;
        st.out_empty         = '0;
        st.out_startofpacket = '0;
        st.out_endofpacket   = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            st.out_data[i*DATA_W +: DATA_W]    = w_out_beat[i].data;
            st.out_empty[i*EMPTY_W +: EMPTY_W] = w_out_beat[i].empty;
            st.out_startofpacket[i]            = w_out_beat[i].sop;
            st.out_endofpacket[i]              = w_out_beat[i].eop;
        end
    end

    assign st.out_valid   = w_out_valid;
    assign st.in_ready    = w_in_ready;
    assign drop_pkt_cnt   = r_drop_cnt;
    assign err_beat_cnt   = r_err_cnt;

endmodule

// File: doc/st_demux_pkt.md
Name: st_demux_pkt

Overview:
Packet-atomic Avalon-ST demultiplexer, the inverse of the packet mux. One 512-bit ingress stream with a per-packet channel sideband is split onto NUM_OUT egress streams. The egress channel is latched on the SOP beat and held until the EOP beat. Each egress has a 2-entry skid buffer, so egress ready never reaches in_ready combinationally. It sits between the ingress pipeline and per-destination consumers such as the DMA path, the reassembly path and the drop/host path.

Parameters:
DATA_W, 512, beat data width
EMPTY_W, 6, empty-byte count width
NUM_OUT, 3, number of egress streams (2..4)
CH_W, 2, in_channel width; a channel value >= NUM_OUT selects drop
CNT_W, 32, statistics counter width

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous active-low reset
in_data  in  DATA_W  ingress beat data
in_valid  in  1  ingress beat valid
in_ready  out  1  ingress ready
in_startofpacket  in  1  first beat of packet
in_endofpacket  in  1  last beat of packet
in_empty  in  EMPTY_W  empty bytes; meaningful on EOP only
in_channel  in  CH_W  destination; sampled on SOP beat only
out_data  out  NUM_OUT*DATA_W  egress data; slice i belongs to egress i
out_valid  out  NUM_OUT  egress valid
out_ready  in  NUM_OUT  egress ready
out_startofpacket  out  NUM_OUT  egress SOP
out_endofpacket  out  NUM_OUT  egress EOP
out_empty  out  NUM_OUT*EMPTY_W  egress empty
drop_pkt_cnt  out  CNT_W  packets discarded because of an invalid channel
err_beat_cnt  out  CNT_W  protocol-error beats

Behaviour:
- Reset (Rst_n low, asynchronous):
  - State goes to IDLE; cur_ch=0.
  - All skid buffers are emptied; out_valid=0.
  - out_data, out_empty, out_startofpacket and out_endofpacket are 0.
  - Both counters are 0; in_ready=0 while Rst_n is low.
  - Reset asserted mid-packet discards buffered beats. No EOP is synthesised.
- Beat accepted: in_valid & in_ready.
- in_ready:
  - IDLE: ~full[in_channel] for a valid channel; 1 for an invalid channel.
  - FWD: ~full[cur_ch].
  - DROP: 1.
  - full[i] is a register bit (2 entries occupied). The only combinational input path to in_ready is in_channel.
- State machine (IDLE, FWD, DROP):
  - IDLE, accepted beat with SOP:
    - Valid channel: push beat to egress in_channel. cur_ch<=in_channel. If EOP is not set, go to FWD.
    - Invalid channel: discard the beat. If EOP is not set, go to DROP. drop_pkt_cnt+1 on the SOP beat.
  - IDLE, accepted beat without SOP: discard; err_beat_cnt+1; stay in IDLE.
  - FWD, accepted beat: push to cur_ch. If SOP is set, err_beat_cnt+1 and the beat is still forwarded with SOP cleared. Return to IDLE on EOP.
  - DROP, accepted beat: discard. A SOP beat here also counts err_beat_cnt+1. Return to IDLE on EOP.
  - Single-beat packet (SOP&EOP) stays in IDLE.
- Skid buffer per egress:
  - 2-entry FIFO holding {data, sop, eop, empty}; outputs are driven from the head register.
  - Push and pop in the same cycle are both performed, including when the buffer is full.
  - Latency is 1 cycle from accepted beat to out_valid with an empty buffer and out_ready held high.
  - Sustains 1 beat/clk per egress.
- No egress interleaves packets; beat order within an egress is preserved.
- Counters saturate at all-ones and never wrap.
- out_valid never drops without a handshake (Avalon-ST compliant).

Decomposition:
- Shared package (pkt_st_pkg):
  - Beat struct {data, sop, eop, empty}.
  - Demux state enum {IDLE, FWD, DROP}.
  - DATA_W and EMPTY_W constants; these are shared with the mux.
- Sub-module st_skid2: 2-entry valid/ready skid buffer, instantiated NUM_OUT times through a generate loop. The top level holds the FSM, steering and counters.

Test Plan:
- Single-beat packets to ch0, ch1, ch2 back-to-back, all out_ready=1 -> each appears once on its egress one cycle after acceptance, with sop=eop=1 and empty preserved (e.g. 5). in_ready stays 1.
- 4-beat packet to ch1 with in_channel toggling to 0 on beats 2-4 -> all 4 beats on egress 1, none on 0. Egress-1 SOP only on beat 1; EOP with empty=12 on beat 4.
- Backpressure: out_ready[2]=0, 5-beat packet to ch2 -> exactly 2 beats accepted, then in_ready=0. Release out_ready[2] -> remaining 3 beats flow with data order intact. Egress 0 and 1 are unaffected.
- Invalid channel 3, 3-beat packet, then valid packet to ch0 -> no egress activity for the first packet. drop_pkt_cnt=1; second packet delivered intact.
- Protocol errors: non-SOP beat in IDLE, then SOP beat mid-packet in FWD -> err_beat_cnt=2. The orphan beat is discarded; the mid-packet beat is forwarded with sop=0.
- Assert Rst_n low for one cycle while egress 1 holds 2 beats mid-packet -> out_valid=0 immediately (asynchronous). After release: state IDLE, counters 0, a new SOP on ch1 is delivered correctly.
